// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues in-order word reads to instruction memory,
// buffers returned words in a small prefetch queue and hands them to decode
// tagged with their address. A redirect flushes the queue, discards in-flight
// responses and restarts fetch at the new (word-aligned) address.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to turn a misaligned
// redirect into a single fault marker entry instead of silently aligning it.
module instruction_fetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_address,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_address,
    output logic                  inst_fault
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]      LAST_PTR    = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]        CREDIT_CAP  = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP   = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(3);

    typedef enum logic [1:0] {
        WAIT,
        RUN
`ifdef FETCH_MISALIGN_CHECK_EN
        , FAULT
`endif
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      discard;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [DATA_WIDTH-1:0] q_data [DEPTH];
    logic [ADDR_WIDTH-1:0] q_addr [DEPTH];
`ifdef FETCH_MISALIGN_CHECK_EN
    logic                  q_fault [DEPTH];
    logic                  fault_pending;
    logic [ADDR_WIDTH-1:0] fault_address;
    logic                  fault_push;
`endif

    logic                  queue_nonempty;
    logic                  pop;
    logic                  req_fire;
    logic                  resp_keep;
    logic                  push;
    logic [CNT_W:0]        in_use;
    logic [ADDR_WIDTH-1:0] aligned_redirect;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshakes and credit: a slot freed by this cycle's pop can be reused
    // by a new request, which keeps k=1 memory at one instruction per cycle.
    always_comb begin
        queue_nonempty   = (count != '0);
        inst_valid       = queue_nonempty && !redirect;
        pop              = inst_valid && inst_ready;
        in_use           = {1'b0, outstanding} + {1'b0, count} - {{CNT_W{1'b0}}, pop};
        mem_req_valid    = (state == RUN) && !redirect && (in_use < CREDIT_CAP);
        mem_req_addr     = fetch_pc;
        req_fire         = mem_req_valid && mem_req_ready;
        resp_keep        = mem_resp_valid && (discard == '0);
        aligned_redirect = redirect_address & ~OFFSET_MASK;
        inst_data        = queue_nonempty ? q_data[head] : '0;
        inst_address     = queue_nonempty ? q_addr[head] : '0;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_push       = (state == FAULT) && fault_pending && !queue_nonempty;
        push             = resp_keep || fault_push;
        inst_fault       = queue_nonempty ? q_fault[head] : 1'b0;
`else
        push             = resp_keep;
        inst_fault       = 1'b0;
`endif
    end

    // Fetch state, counters and prefetch queue; redirect overrides request,
    // response write and pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT;
            fetch_pc    <= '0;
            resp_pc     <= '0;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_pending <= 1'b0;
            fault_address <= '0;
`endif
        end else if (redirect) begin
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            outstanding <= outstanding - CNT_W'(mem_resp_valid);
            discard     <= outstanding - CNT_W'(mem_resp_valid);
            fetch_pc    <= aligned_redirect;
            resp_pc     <= aligned_redirect;
`ifdef FETCH_MISALIGN_CHECK_EN
            if ((redirect_address & OFFSET_MASK) != '0) begin
                state         <= FAULT;
                fault_pending <= 1'b1;
                fault_address <= redirect_address;
            end else begin
                state         <= RUN;
                fault_pending <= 1'b0;
            end
`else
            state <= RUN;
`endif
        end else begin
            if (state == WAIT) begin
                state <= RUN;
            end
            if (req_fire) begin
                fetch_pc <= fetch_pc + WORD_STEP;
            end
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(mem_resp_valid);
            if (mem_resp_valid && (discard != '0)) begin
                discard <= discard - CNT_W'(1);
            end
            if (resp_keep) begin
                q_data[tail] <= mem_resp_data;
                q_addr[tail] <= resp_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
                q_fault[tail] <= 1'b0;
`endif
                tail    <= ptr_next(tail);
                resp_pc <= resp_pc + WORD_STEP;
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            else if (fault_push) begin
                q_data[tail]  <= '0;
                q_addr[tail]  <= fault_address;
                q_fault[tail] <= 1'b1;
                tail          <= ptr_next(tail);
                fault_pending <= 1'b0;
            end
`endif
            if (pop) begin
                head <= ptr_next(head);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a behavioural memory with configurable
// latency, and a scoreboard of expected instructions filled as requests are
// accepted and drained as decode pops them.
`timescale 1ns/1ps
module tb_instruction_fetch;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_address = '0;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b1;
    logic [AW-1:0] mem_req_addr;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_resp_data = '0;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_address;
    logic          inst_fault;

    always #5 clk = ~clk;

    instruction_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .redirect(redirect), .redirect_address(redirect_address),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_address(inst_address), .inst_fault(inst_fault)
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; logic fault; } exp_t;
    typedef struct { int due; logic [31:0] data; } resp_t;

    exp_t        expQ[$];
    resp_t       respQ[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cycle = 0;
    int          pops = 0;
    int          fires = 0;
    int          memLatency = 1;
    logic [31:0] modelPc = '0;
    bit          faultMode = 1'b0;
    bit          wrapSeen = 1'b0;
    logic [31:0] prevFireAddr = '0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs after the edge, observe at the falling edge.
    task automatic applyStimulus(input logic rdr, input logic [31:0] raddr, input logic rdy, input logic memRdy);
        exp_t e;
        @(posedge clk);
        #1;
        cycle++;
        if (respQ.size() > 0 && respQ[0].due == cycle) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = respQ[0].data;
            respQ.delete(0);
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
        end
        redirect         = rdr;
        redirect_address = raddr;
        inst_ready       = rdy;
        mem_req_ready    = memRdy;
        @(negedge clk);
        if (rdr) begin
            checkOutput("redirect_blocks_req", {31'b0, mem_req_valid}, 32'd0);
            checkOutput("redirect_blocks_inst", {31'b0, inst_valid}, 32'd0);
            expQ.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
            if (raddr[1:0] != 2'b00) begin
                faultMode = 1'b1;
                expQ.push_back('{addr: raddr, data: 32'd0, fault: 1'b1});
            end else begin
                faultMode = 1'b0;
                modelPc   = raddr & ~32'h3;
            end
`else
            modelPc = raddr & ~32'h3;
`endif
        end else begin
            if (mem_req_valid && memRdy) begin
                fires++;
                if (mem_req_addr == 32'd0 && prevFireAddr == 32'hFFFF_FFFC) wrapSeen = 1'b1;
                prevFireAddr = mem_req_addr;
                if (faultMode) begin
                    checkOutput("req_in_fault", {31'b0, mem_req_valid}, 32'd0);
                end else begin
                    checkOutput("req_addr", mem_req_addr, modelPc);
                    expQ.push_back('{addr: modelPc, data: memWord(modelPc), fault: 1'b0});
                    respQ.push_back('{due: cycle + memLatency, data: memWord(mem_req_addr)});
                    modelPc = modelPc + 32'd4;
                end
            end
            if (inst_valid && rdy) begin
                pops++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_inst", {31'b0, inst_valid}, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("inst_address", inst_address, e.addr);
                    checkOutput("inst_data", inst_data, e.data);
                    checkOutput("inst_fault", {31'b0, inst_fault}, {31'b0, e.fault});
                end
            end
        end
    endtask

    // Synchronous reset; checks outputs the cycle after rst is seen and the WAIT cycle.
    task automatic resetDut();
        @(posedge clk);
        #1;
        rst = 1'b1;
        redirect = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        checkOutput("rst_mem_req_addr", mem_req_addr, 32'd0);
        checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("rst_inst_data", inst_data, 32'd0);
        checkOutput("rst_inst_address", inst_address, 32'd0);
        checkOutput("rst_inst_fault", {31'b0, inst_fault}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        respQ.delete();
        modelPc = '0;
        faultMode = 1'b0;
        cycle = 1;
        @(negedge clk);
        checkOutput("wait_no_req", {31'b0, mem_req_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Streaming with k=1 memory: first inst on cycle 4, one per cycle after.
        memLatency = 1;
        resetDut();
        pops = 0;
        for (int c = 2; c <= 12; c++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
            checkOutput("stream_req_valid", {31'b0, mem_req_valid}, 32'd1);
            checkOutput("stream_inst_valid", {31'b0, inst_valid}, {31'b0, (cycle >= 4)});
        end
        checkOutput("stream_pop_count", pops, 32'd9);

        // Redirect timing: request at R+1, instruction visible at R+3.
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
        checkOutput("redir_req_r1", {31'b0, mem_req_valid}, 32'd1);
        checkOutput("redir_addr_r1", mem_req_addr, 32'h100);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
        checkOutput("redir_inst_r2", {31'b0, inst_valid}, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
        checkOutput("redir_inst_r3", {31'b0, inst_valid}, 32'd1);
        repeat (3) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);

        // Backpressure: exactly DEPTH requests, then none until a pop.
        resetDut();
        fires = 0;
        repeat (8) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("stall_fire_count", fires, 32'd2);
        checkOutput("stall_req_valid", {31'b0, mem_req_valid}, 32'd0);
        checkOutput("stall_head_valid", {31'b0, inst_valid}, 32'd1);
        checkOutput("stall_head_addr", inst_address, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
        checkOutput("req_on_pop", {31'b0, mem_req_valid}, 32'd1);
        repeat (4) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);

        // Redirect with two requests outstanding on a k=3 memory: both dropped.
        memLatency = 3;
        resetDut();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
        pops = 0;
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1);
        repeat (14) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
        checkOutput("drop_then_deliver", {31'b0, (pops >= 3)}, 32'd1);

        // Address wrap with a memory that accepts every other cycle.
        memLatency = 1;
        resetDut();
        wrapSeen = 1'b0;
        applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, (i % 2) == 0);
        end
        checkOutput("pc_wrap_to_zero", {31'b0, wrapSeen}, 32'd1);

        // Misaligned redirect.
        pops = 0;
        fires = 0;
        applyStimulus(1'b1, 32'h102, 1'b1, 1'b1);
        repeat (6) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
`ifdef FETCH_MISALIGN_CHECK_EN
        checkOutput("fault_single_pop", pops, 32'd1);
        checkOutput("fault_no_fires", fires, 32'd0);
        checkOutput("fault_then_idle", {31'b0, inst_valid}, 32'd0);
`else
        checkOutput("misalign_cleared_pops", pops, 32'd4);
`endif
        pops = 0;
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
        repeat (6) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
        checkOutput("resume_pops", pops, 32'd4);

        // Reset with a full queue, then fetch restarts at 0.
        repeat (6) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        resetDut();
        pops = 0;
        repeat (6) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
        checkOutput("post_reset_pops", pops, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
